// File: rtl/cell_bist_pkg.sv
// Shared definitions for the cell BIST controllers: FSM state encoding and
// the counter widths used by the vector, settle and error counters.
package cell_bist_pkg;

   localparam int VEC_W = 4;
   localparam int ERR_W = VEC_W + 1;
   localparam int SET_W = 4;
   localparam logic [VEC_W-1:0] VEC_LAST = '1;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      CHECK,
      FIN
   } bist_state_e;

endpackage

// File: rtl/aoi211_golden.sv
// Golden model of an AOI211 cell: ZN = ~(A | B | (C1 & C2)).
// Purely combinational so other cell BIST controllers can reuse it.
module aoi211_golden (
   input  logic i_a,
   input  logic i_b,
   input  logic i_c1,
   input  logic i_c2,
   output logic o_zn
);

   assign o_zn = ~(i_a | i_b | (i_c1 & i_c2));

endmodule

// File: rtl/aoi211_bist_ctrl.sv
// Exhaustive BIST controller for an AOI211 cell: steps through all 16 input
// vectors, waits SETTLE cycles per vector, and counts ZN mismatches.
module aoi211_bist_ctrl
   import cell_bist_pkg::*;
#(
   parameter int unsigned SETTLE = 2
) (
   input  logic             CK,
   input  logic             RST,
   input  logic             START,
   input  logic             ABORT,
   input  logic             ZN_IN,
   output logic             A,
   output logic             B,
   output logic             C1,
   output logic             C2,
   output logic             BUSY,
   output logic             DONE,
   output logic             PASS,
   output logic [ERR_W-1:0] ERR_CNT,
   output logic [VEC_W-1:0] FIRST_FAIL
);

   bist_state_e      r_state;
   bist_state_e      w_next;
   logic [VEC_W-1:0] r_vec;
   logic [SET_W-1:0] r_settle;
   logic [ERR_W-1:0] r_errCnt;
   logic [VEC_W-1:0] r_firstFail;
   logic             r_busy;
   logic             r_done;
   logic             r_pass;
   logic             w_expected;
   logic             w_abort;
   logic             w_mismatch;

   // Expected response is derived from the registered stimulus, not the counter input.
   aoi211_golden u_golden (
      .i_a  (r_vec[3]),
      .i_b  (r_vec[2]),
      .i_c1 (r_vec[1]),
      .i_c2 (r_vec[0]),
      .o_zn (w_expected)
   );

   assign w_abort    = ABORT && (r_state != IDLE);
   assign w_mismatch = (r_state == CHECK) && (ZN_IN != w_expected);

   always_ff @(posedge CK or posedge RST) begin
      if (RST) r_state <= IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      if (w_abort) begin
         w_next = IDLE;
      end else begin
         case (r_state)
            IDLE:    if (START) w_next = WAIT;
            WAIT:    if (r_settle == SET_W'(1)) w_next = CHECK;
            CHECK:   w_next = (r_vec == VEC_LAST) ? FIN : WAIT;
            FIN:     w_next = IDLE;
            default: w_next = IDLE;
         endcase
      end
   end

   // Abort beats everything; error count and first-fail index deliberately keep partial values.
   always_ff @(posedge CK or posedge RST) begin
      if (RST) begin
         r_vec       <= '0;
         r_settle    <= '0;
         r_errCnt    <= '0;
         r_firstFail <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_pass      <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (w_abort) begin
            r_vec  <= '0;
            r_busy <= 1'b0;
            r_pass <= 1'b0;
         end else begin
            case (r_state)
               IDLE: begin
                  if (START) begin
                     r_vec       <= '0;
                     r_settle    <= SET_W'(SETTLE);
                     r_errCnt    <= '0;
                     r_firstFail <= '0;
                     r_pass      <= 1'b0;
                     r_busy      <= 1'b1;
                  end
               end
               WAIT: r_settle <= r_settle - SET_W'(1);
               CHECK: begin
                  if (w_mismatch) begin
                     r_errCnt <= r_errCnt + ERR_W'(1);
                     if (r_errCnt == '0) r_firstFail <= r_vec;
                  end
                  if (r_vec != VEC_LAST) begin
                     r_vec    <= r_vec + VEC_W'(1);
                     r_settle <= SET_W'(SETTLE);
                  end
               end
               FIN: begin
                  r_done <= 1'b1;
                  r_pass <= (r_errCnt == '0);
                  r_vec  <= '0;
                  r_busy <= 1'b0;
               end
               default: r_vec <= '0;
            endcase
         end
      end
   end

   assign A          = r_vec[3];
   assign B          = r_vec[2];
   assign C1         = r_vec[1];
   assign C2         = r_vec[0];
   assign BUSY       = r_busy;
   assign DONE       = r_done;
   assign PASS       = r_pass;
   assign ERR_CNT    = r_errCnt;
   assign FIRST_FAIL = r_firstFail;

endmodule

// File: tb/tb_aoi211_bist_ctrl.sv
// Directed bench for aoi211_bist_ctrl: fault-free cell, stuck-at cells,
// abort, START spam and mid-test reset, with hand-computed expectations.
module tb_aoi211_bist_ctrl;

   logic       clock;
   logic       rst;
   logic       start;
   logic       abort;
   logic       zn;
   logic       a, b, c1, c2;
   logic       busy, done, pass;
   logic [4:0] errCnt;
   logic [3:0] firstFail;
   int         cellMode;
   int         vecCount;
   int         missCount;
   int         cycles;
   int         dones;
   logic [3:0] stimAt3;

   aoi211_bist_ctrl #(.SETTLE(2)) dut (
      .CK         (clock),
      .RST        (rst),
      .START      (start),
      .ABORT      (abort),
      .ZN_IN      (zn),
      .A          (a),
      .B          (b),
      .C1         (c1),
      .C2         (c2),
      .BUSY       (busy),
      .DONE       (done),
      .PASS       (pass),
      .ERR_CNT    (errCnt),
      .FIRST_FAIL (firstFail)
   );

   // Cell under test: 0 = healthy AOI211, 1 = stuck-at-0, 2 = stuck-at-1.
   assign zn = (cellMode == 0) ? ~(a | b | (c1 & c2)) : (cellMode == 2);

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [3:0] stim();
      return {a, b, c1, c2};
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecCount++;
      assert (obs === exp) else begin
         missCount++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic applyStimulus();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Counts cycles from the accept edge to DONE; optionally hammers START meanwhile.
   task automatic waitDone(input bit spam, output int nCycles, output logic [3:0] s3);
      nCycles = 0;
      s3 = 4'hx;
      while (nCycles < 200) begin
         if (spam) start = nCycles[0];
         tick();
         nCycles++;
         if (nCycles == 3) s3 = stim();
         if (done) break;
      end
      start = 1'b0;
   endtask

   initial begin
      vecCount  = 0;
      missCount = 0;
      cellMode  = 0;
      start     = 1'b0;
      abort     = 1'b0;
      rst       = 1'b1;
      repeat (2) tick();
      checkOutput("reset_busy", busy, 0);
      checkOutput("reset_done", done, 0);
      checkOutput("reset_pass", pass, 0);
      checkOutput("reset_err", errCnt, 0);
      checkOutput("reset_stim", stim(), 0);

      rst = 1'b0;
      applyStimulus();
      checkOutput("first_start_busy", busy, 1);
      checkOutput("first_start_stim", stim(), 0);
      waitDone(1'b0, cycles, stimAt3);
      checkOutput("good_latency", cycles, 49);
      checkOutput("good_vec1_stim", stimAt3, 1);
      checkOutput("good_pass", pass, 1);
      checkOutput("good_err", errCnt, 0);
      checkOutput("good_busy_at_done", busy, 0);
      checkOutput("good_stim_at_done", stim(), 0);
      tick();
      checkOutput("good_done_single", done, 0);
      checkOutput("good_pass_hold", pass, 1);

      cellMode = 1;
      applyStimulus();
      checkOutput("sa0_pass_cleared", pass, 0);
      waitDone(1'b0, cycles, stimAt3);
      checkOutput("sa0_latency", cycles, 49);
      checkOutput("sa0_err", errCnt, 3);
      checkOutput("sa0_first", firstFail, 0);
      checkOutput("sa0_pass", pass, 0);

      cellMode = 2;
      applyStimulus();
      waitDone(1'b0, cycles, stimAt3);
      checkOutput("sa1_err", errCnt, 13);
      checkOutput("sa1_first", firstFail, 3);
      checkOutput("sa1_pass", pass, 0);
      repeat (5) tick();
      checkOutput("sa1_err_hold", errCnt, 13);
      checkOutput("sa1_first_hold", firstFail, 3);

      // Vector 5 is driven 15 edges after accept; one more edge keeps it in WAIT.
      applyStimulus();
      repeat (16) tick();
      checkOutput("abort_pre_stim", stim(), 5);
      checkOutput("abort_pre_err", errCnt, 2);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      checkOutput("abort_busy", busy, 0);
      checkOutput("abort_stim", stim(), 0);
      checkOutput("abort_done", done, 0);
      checkOutput("abort_pass", pass, 0);
      checkOutput("abort_err_hold", errCnt, 2);
      checkOutput("abort_first_hold", firstFail, 3);
      repeat (60) begin
         tick();
         if (done || busy) break;
      end
      checkOutput("abort_no_done", {busy, done}, 0);

      cellMode = 0;
      applyStimulus();
      waitDone(1'b0, cycles, stimAt3);
      checkOutput("rerun_latency", cycles, 49);
      checkOutput("rerun_pass", pass, 1);
      checkOutput("rerun_err", errCnt, 0);

      applyStimulus();
      waitDone(1'b1, cycles, stimAt3);
      checkOutput("spam_latency", cycles, 49);
      checkOutput("spam_pass", pass, 1);
      tick();
      checkOutput("spam_single_done", {busy, done}, 0);

      // Vector 9 is driven 27 edges after accept and reaches CHECK two edges later.
      cellMode = 2;
      applyStimulus();
      repeat (29) tick();
      checkOutput("rst_pre_stim", stim(), 9);
      checkOutput("rst_pre_err", errCnt, 6);
      #2 rst = 1'b1;
      #1;
      checkOutput("rst_mid_busy", busy, 0);
      checkOutput("rst_mid_stim", stim(), 0);
      checkOutput("rst_mid_err", errCnt, 0);
      checkOutput("rst_mid_first", firstFail, 0);
      checkOutput("rst_mid_flags", {done, pass}, 0);
      tick();
      rst = 1'b0;
      applyStimulus();
      checkOutput("post_rst_start", busy, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule

// File: doc/aoi211_bist_ctrl.md
AOI211_BIST_CTRL -- requirements
Module: aoi211_bist_ctrl

Interface
REQ-001 Parameter SETTLE, default 2, cycles between applying a vector and sampling ZN_IN (legal 1..15).
REQ-002 CK  input  1  sole clock, all state on rising edge.
REQ-003 RST  input  1  reset, asynchronous, active-high.
REQ-004 START  input  1  one-cycle request to begin exhaustive test; honoured only in IDLE.
REQ-005 ABORT  input  1  terminate running test; honoured in any non-IDLE state.
REQ-006 ZN_IN  input  1  output of the AOI211 cell under test.
REQ-007 A, B, C1, C2  output  1 each  registered stimulus to cell under test.
REQ-008 BUSY  output  1  high while a test is running.
REQ-009 DONE  output  1  one-cycle pulse on normal completion.
REQ-010 PASS  output  1  high when the last completed test had zero mismatches.
REQ-011 ERR_CNT  output  5  mismatches in the current/last test, 0..16.
REQ-012 FIRST_FAIL  output  4  index of first mismatching vector; valid when ERR_CNT != 0.

Function
REQ-013 States SHALL be IDLE, WAIT, CHECK, FIN.
REQ-014 Vector index VEC[3:0] SHALL map {A,B,C1,C2} = VEC[3:0], A = MSB.
REQ-015 Expected value SHALL be ~(A | B | (C1 & C2)), computed from the registered stimulus.
REQ-016 IDLE + START: next edge loads VEC=0, drives vector 0, clears ERR_CNT and FIRST_FAIL, clears PASS, loads settle counter with SETTLE, enters WAIT; BUSY=1.
REQ-017 WAIT: decrement settle counter each cycle; on the cycle it reads 1, enter CHECK.
REQ-018 CHECK: sample ZN_IN once; on mismatch, increment ERR_CNT, and if ERR_CNT was 0, load FIRST_FAIL=VEC.
REQ-019 CHECK with VEC<15: increment VEC, drive new vector, reload settle counter, return to WAIT.
REQ-020 CHECK with VEC=15: enter FIN; no wrap to vector 0.
REQ-021 FIN: DONE=1 for exactly one cycle, PASS=(ERR_CNT==0), stimulus returns to 0000, BUSY=0, next state IDLE.
REQ-022 Each vector SHALL take SETTLE+1 cycles; START-accept edge to DONE high SHALL be 16*(SETTLE+1)+1 cycles.
REQ-023 START while BUSY SHALL be ignored with no effect on the run.
REQ-024 ABORT (takes priority over START and CHECK in the same cycle): next edge to IDLE, stimulus 0000, BUSY=0, DONE not pulsed, PASS=0, ERR_CNT/FIRST_FAIL hold partial values.
REQ-025 ERR_CNT, FIRST_FAIL, PASS SHALL hold after FIN until the next accepted START.
REQ-026 Stimulus outputs SHALL change only on state transitions, never combinationally from inputs.

Reset
REQ-027 RST asserted SHALL immediately force IDLE, VEC=0, A=B=C1=C2=0, BUSY=0, DONE=0, PASS=0, ERR_CNT=0, FIRST_FAIL=0, including mid-test.
REQ-028 First START SHALL be accepted on the first rising CK edge after RST deassertion.

Structure
REQ-029 State encoding enum and the vector width constant SHALL live in shared package cell_bist_pkg.
REQ-030 Expected-value function SHALL be a sub-module aoi211_golden (combinational, 4 in / 1 out), reusable for other cell BIST controllers.
REQ-031 Single FSM plus settle counter, vector counter and error counter; no other sub-modules.

Verification
REQ-032 Correct AOI211 model on ZN_IN, SETTLE=2, START -> DONE 49 cycles after accept edge, PASS=1, ERR_CNT=0.
REQ-033 ZN_IN stuck-at-0 -> ERR_CNT=3, FIRST_FAIL=0, PASS=0.
REQ-034 ZN_IN stuck-at-1 -> ERR_CNT=13, FIRST_FAIL=3, PASS=0.
REQ-035 ABORT at vector 5 in WAIT -> IDLE next edge, no DONE, BUSY=0, stimulus 0000; second START runs full test normally.
REQ-036 START pulsed repeatedly during run -> timing unchanged, single DONE; RST during CHECK of vector 9 -> all outputs zero immediately.
